// File: rtl/ise_rank_collector.sv
// Rank collector: captures a 32-entry sorted burst, tracks per-colour counts and
// integrity flags, then serves host readout of the captured ranks.
module ise_rank_collector #(
  parameter int unsigned NUM_IMG = 32,
  parameter int unsigned IDX_W   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             out_valid,
  input  logic [1:0]       color_index,
  input  logic [IDX_W-1:0] image_out_index,
  output logic             frame_done,
  output logic             frame_ok,
  output logic             err_dup,
  output logic             err_order,
  output logic             err_color,
  output logic [IDX_W:0]   cnt_red,
  output logic [IDX_W:0]   cnt_green,
  output logic [IDX_W:0]   cnt_blue,
  input  logic             rd_req,
  input  logic [IDX_W-1:0] rd_rank,
  output logic             rd_valid,
  output logic [IDX_W-1:0] rd_image,
  output logic [1:0]       rd_color
);

  localparam int unsigned CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     rank_q, rank_d;
  logic [NUM_IMG-1:0]   seen_q, seen_d;
  logic [1:0]           prev_q, prev_d;
  logic [CNT_W-1:0]     cnt_r_q, cnt_r_d, cnt_g_q, cnt_g_d, cnt_b_q, cnt_b_d;
  logic                 dup_q, dup_d, ord_q, ord_d, col_q, col_d;
  logic                 done_q, done_d, ok_q, ok_d;
  logic                 rv_q, rv_d;
  logic [IDX_W-1:0]     ri_q, ri_d;
  logic [1:0]           rc_q, rc_d;
  logic [IDX_W+1:0]     mem_q [NUM_IMG];
  logic [IDX_W+1:0]     rd_word;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_W'(NUM_IMG)) ? c : c + 1'b1;
  endfunction

  assign rd_word = mem_q[rd_rank];

  always_comb begin
    state_d = state_q;
    rank_d  = rank_q;
    seen_d  = seen_q;
    prev_d  = prev_q;
    cnt_r_d = cnt_r_q;
    cnt_g_d = cnt_g_q;
    cnt_b_d = cnt_b_q;
    dup_d   = dup_q;
    ord_d   = ord_q;
    col_d   = col_q;
    done_d  = 1'b0;
    ok_d    = ok_q;
    rv_d    = 1'b0;
    ri_d    = ri_q;
    rc_d    = rc_q;

    if (out_valid) begin
      // Any capture outside CAPTURE opens a fresh frame: bookkeeping restarts
      // from this entry alone before it is accumulated below.
      if (state_q != S_CAPTURE) begin
        seen_d  = '0;
        prev_d  = '0;
        cnt_r_d = '0;
        cnt_g_d = '0;
        cnt_b_d = '0;
        dup_d   = 1'b0;
        ord_d   = 1'b0;
        col_d   = 1'b0;
        ok_d    = 1'b0;
      end
      dup_d = dup_d | seen_d[image_out_index];
      seen_d[image_out_index] = 1'b1;
      if (rank_q != '0)
        ord_d = ord_d | (color_index < prev_d);
      col_d = col_d | (color_index == 2'd3);
      case (color_index)
        2'd0:    begin cnt_r_d = sat_inc(cnt_r_d); prev_d = color_index; end
        2'd1:    begin cnt_g_d = sat_inc(cnt_g_d); prev_d = color_index; end
        2'd2:    begin cnt_b_d = sat_inc(cnt_b_d); prev_d = color_index; end
        default: ;
      endcase
      rank_d = rank_q + 1'b1;
      if (rank_q == IDX_W'(NUM_IMG - 1)) begin
        state_d = S_DONE;
        done_d  = 1'b1;
        ok_d    = !(dup_d | ord_d | col_d);
      end else begin
        state_d = S_CAPTURE;
      end
    end else if (rd_req && (state_q == S_DONE)) begin
      rv_d = 1'b1;
      ri_d = rd_word[IDX_W+1:2];
      rc_d = rd_word[1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      rank_q  <= '0;
      seen_q  <= '0;
      prev_q  <= '0;
      cnt_r_q <= '0;
      cnt_g_q <= '0;
      cnt_b_q <= '0;
      dup_q   <= 1'b0;
      ord_q   <= 1'b0;
      col_q   <= 1'b0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      rv_q    <= 1'b0;
      ri_q    <= '0;
      rc_q    <= '0;
    end else begin
      state_q <= state_d;
      rank_q  <= rank_d;
      seen_q  <= seen_d;
      prev_q  <= prev_d;
      cnt_r_q <= cnt_r_d;
      cnt_g_q <= cnt_g_d;
      cnt_b_q <= cnt_b_d;
      dup_q   <= dup_d;
      ord_q   <= ord_d;
      col_q   <= col_d;
      done_q  <= done_d;
      ok_q    <= ok_d;
      rv_q    <= rv_d;
      ri_q    <= ri_d;
      rc_q    <= rc_d;
    end
  end

  // Buffer contents are don't-care after reset, so it carries no reset.
  always_ff @(posedge clk) begin
    if (out_valid)
      mem_q[rank_q] <= {image_out_index, color_index};
  end

  assign frame_done = done_q;
  assign frame_ok   = ok_q;
  assign err_dup    = dup_q;
  assign err_order  = ord_q;
  assign err_color  = col_q;
  assign cnt_red    = cnt_r_q;
  assign cnt_green  = cnt_g_q;
  assign cnt_blue   = cnt_b_q;
  assign rd_valid   = rv_q;
  assign rd_image   = ri_q;
  assign rd_color   = rc_q;

endmodule
